// File: rtl/uart_udp_packetizer_if.sv
// Handshake bundle between the UART byte source, the packetizer and the UDP transmitter.
// slave is the packetizer's view; master is the environment driving bytes and tx_ready.
interface uart_udp_packetizer_if #(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned DROP_W    = 16
);
  localparam int unsigned SIZE_W = $clog2(MAX_BYTES + 1);

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   tx_ready;
  logic                   tx_send;
  logic [MAX_BYTES*8-1:0] tx_data;
  logic [SIZE_W-1:0]      tx_size;
  logic                   busy;
  logic [DROP_W-1:0]      dropped;

  modport master (
    output in_data, in_valid, tx_ready,
    input  tx_send, tx_data, tx_size, busy, dropped
  );

  modport slave (
    input  in_data, in_valid, tx_ready,
    output tx_send, tx_data, tx_size, busy, dropped
  );
endinterface

// File: rtl/uart_udp_packetizer.sv
// Double-buffered UART-to-UDP payload packer: one bank fills while the other is sent,
// flushing on full or after an idle timeout.
module uart_udp_packetizer #(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned TIMEOUT   = 100000,
  parameter int unsigned DROP_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  uart_udp_packetizer_if.slave bus
);
  localparam int unsigned DATA_W = MAX_BYTES * 8;
  localparam int unsigned SIZE_W = $clog2(MAX_BYTES + 1);
  localparam int unsigned TMR_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SIZE_W-1:0] FULL_CNT = SIZE_W'(MAX_BYTES);
  localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StAck, StDone} state_e;

  state_e            r_state;
  logic [DATA_W-1:0] r_buf   [2];
  logic [SIZE_W-1:0] r_count [2];
  logic              r_fill;
  logic [TMR_W-1:0]  r_timer;
  logic              r_pend;
  logic              r_tx_send;
  logic [DATA_W-1:0] r_tx_data;
  logic [SIZE_W-1:0] r_tx_size;
  logic              r_busy;
  logic [DROP_W-1:0] r_dropped;

  logic [SIZE_W-1:0] w_cnt;
  logic              w_full;
  logic              w_timeout_hit;
  logic              w_handoff;
  logic              w_capture;
  logic              w_drop;
  logic [DATA_W-1:0] w_first;

  assign w_cnt         = r_count[r_fill];
  assign w_full        = (w_cnt == FULL_CNT);
  assign w_timeout_hit = (TIMEOUT != 0) && (w_cnt != '0) && (r_timer == TMR_MAX);
  // A full bank requests immediately; a timeout is latched and served one edge later.
  assign w_handoff     = (r_pend || w_full) && (r_state == StIdle);
  assign w_capture     = bus.in_valid && !w_full && !w_handoff;
  assign w_drop        = bus.in_valid && w_full && !w_handoff;
  assign w_first       = {bus.in_data, {(DATA_W-8){1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_count[0] <= '0;
      r_count[1] <= '0;
      r_fill     <= 1'b0;
      r_timer    <= '0;
      r_pend     <= 1'b0;
      r_tx_send  <= 1'b0;
      r_tx_data  <= '0;
      r_tx_size  <= '0;
      r_busy     <= 1'b0;
      r_dropped  <= '0;
    end else begin
      r_tx_send <= 1'b0;

      if (w_handoff) begin
        // The new fill bank starts zeroed so trailing bytes of a short packet read as 0.
        r_fill           <= ~r_fill;
        r_buf[~r_fill]   <= bus.in_valid ? w_first : '0;
        r_count[~r_fill] <= bus.in_valid ? SIZE_W'(1) : '0;
        r_timer          <= '0;
        r_pend           <= 1'b0;
      end else begin
        if (w_capture) begin
          for (int i = 0; i < MAX_BYTES; i++) begin
            if (w_cnt == SIZE_W'(i)) r_buf[r_fill][DATA_W-1-8*i -: 8] <= bus.in_data;
          end
          r_count[r_fill] <= w_cnt + 1'b1;
          r_timer         <= '0;
        end else if ((w_cnt != '0) && (r_timer != TMR_MAX)) begin
          r_timer <= r_timer + 1'b1;
        end
        r_pend <= r_pend | w_timeout_hit;
      end

      if (w_drop && (r_dropped != '1)) r_dropped <= r_dropped + 1'b1;

      unique case (r_state)
        StIdle: begin
          if (w_handoff) begin
            r_state   <= StReq;
            r_busy    <= 1'b1;
            r_tx_data <= r_buf[r_fill];
            r_tx_size <= w_cnt;
          end
        end
        StReq: begin
          if (bus.tx_ready) begin
            r_tx_send <= 1'b1;
            r_state   <= StAck;
          end
        end
        StAck: begin
          if (!bus.tx_ready) r_state <= StDone;
        end
        StDone: begin
          if (bus.tx_ready) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.tx_send = r_tx_send;
  assign bus.tx_data = r_tx_data;
  assign bus.tx_size = r_tx_size;
  assign bus.busy    = r_busy;
  assign bus.dropped = r_dropped;
endmodule

// File: tb/tb_uart_udp_packetizer.sv
// Directed bench: dut_a (TIMEOUT=20) covers packets, ping-pong, coincident byte and reset;
// dut_b (TIMEOUT=0, DROP_W=4) covers the disabled timeout and drop-counter saturation.
module tb_uart_udp_packetizer;
  localparam int unsigned MB = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_udp_packetizer_if #(.MAX_BYTES(MB), .DROP_W(16)) ifa ();
  uart_udp_packetizer_if #(.MAX_BYTES(MB), .DROP_W(4))  ifb ();

  uart_udp_packetizer #(.MAX_BYTES(MB), .TIMEOUT(20), .DROP_W(16)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ifa)
  );

  uart_udp_packetizer #(.MAX_BYTES(MB), .TIMEOUT(0), .DROP_W(4)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ifb)
  );

  // Transmitter model for dut_a: ready drops for hold_len_a cycles after each send.
  int hold_len_a = 5;
  int busy_cnt_a = 0;
  always @(posedge clk) begin
    if (ifa.tx_send) busy_cnt_a <= hold_len_a;
    else if (busy_cnt_a > 0) busy_cnt_a <= busy_cnt_a - 1;
  end
  assign ifa.tx_ready = (busy_cnt_a == 0);

  int          send_cnt_a  = 0;
  logic [63:0] sent_data_a = '0;
  logic [3:0]  sent_size_a = '0;
  always @(negedge clk) begin
    if (ifa.tx_send) begin
      send_cnt_a  <= send_cnt_a + 1;
      sent_data_a <= ifa.tx_data;
      sent_size_a <= ifa.tx_size;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    @(negedge clk);
    ifa.in_data  = d;
    ifa.in_valid = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    @(negedge clk);
    ifb.in_data  = d;
    ifb.in_valid = 1'b1;
    @(negedge clk);
    ifb.in_valid = 1'b0;
  endtask

  task automatic wait_busy_a(input logic want, input int budget, output int lat);
    lat = 0;
    while ((ifa.busy !== want) && (lat < budget)) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_sends_a(input int target, input int budget);
    int k;
    k = 0;
    while ((send_cnt_a != target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
  endtask

  typedef struct {
    int          n;
    logic [63:0] bytes;
    logic [63:0] exp_data;
    logic [3:0]  exp_size;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          base;
    logic [63:0] b;
    logic [15:0] drop_before;

    vecs[0] = '{8, 64'h1122334455667788, 64'h1122334455667788, 4'd8, 1};
    vecs[1] = '{2, 64'hABCDFFFFFFFFFFFF, 64'hABCD000000000000, 4'd2, 22};
    vecs[2] = '{1, 64'h5A77777777777777, 64'h5A00000000000000, 4'd1, 22};
    vecs[3] = '{7, 64'h01020304050607EE, 64'h0102030405060700, 4'd7, 22};
    vecs[4] = '{8, 64'hFFEEDDCCBBAA9988, 64'hFFEEDDCCBBAA9988, 4'd8, 1};

    ifa.in_data  = '0;
    ifa.in_valid = 1'b0;
    ifb.in_data  = '0;
    ifb.in_valid = 1'b0;
    ifb.tx_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset tx_send", 64'(ifa.tx_send), 64'd0);
    check("reset tx_data", ifa.tx_data, 64'd0);
    check("reset tx_size", 64'(ifa.tx_size), 64'd0);
    check("reset busy", 64'(ifa.busy), 64'd0);
    check("reset dropped", 64'(ifa.dropped), 64'd0);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      b = vecs[v].bytes;
      for (int j = 0; j < vecs[v].n; j++) send_a(b[63-8*j -: 8]);
      wait_busy_a(1'b1, 60, lat);
      check($sformatf("v%0d handoff latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      @(negedge clk);
      check($sformatf("v%0d tx_send", v), 64'(ifa.tx_send), 64'd1);
      check($sformatf("v%0d tx_data", v), ifa.tx_data, vecs[v].exp_data);
      check($sformatf("v%0d tx_size", v), 64'(ifa.tx_size), 64'(vecs[v].exp_size));
      @(negedge clk);
      check($sformatf("v%0d tx_send width", v), 64'(ifa.tx_send), 64'd0);
      wait_busy_a(1'b0, 60, lat);
      check($sformatf("v%0d busy release", v), 64'(ifa.busy), 64'd0);
      check($sformatf("v%0d dropped", v), 64'(ifa.dropped), 64'd0);
    end

    // Ping-pong: transmitter stalls after the first send while 20 bytes stream in.
    repeat (3) @(negedge clk);
    base       = send_cnt_a;
    hold_len_a = 60;
    @(negedge clk);
    for (int j = 1; j <= 20; j++) begin
      ifa.in_data  = 8'(j);
      ifa.in_valid = 1'b1;
      @(negedge clk);
    end
    ifa.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pp dropped", 64'(ifa.dropped), 64'd4);
    check("pp first sends", 64'(send_cnt_a - base), 64'd1);
    check("pp first data", sent_data_a, 64'h0102030405060708);
    check("pp tx_data stable", ifa.tx_data, 64'h0102030405060708);
    check("pp busy held", 64'(ifa.busy), 64'd1);
    hold_len_a = 5;
    wait_sends_a(base + 2, 200);
    check("pp second sends", 64'(send_cnt_a - base), 64'd2);
    check("pp second data", sent_data_a, 64'h090A0B0C0D0E0F10);
    check("pp second size", 64'(sent_size_a), 64'd8);
    wait_busy_a(1'b0, 60, lat);

    // Byte arriving on the timeout hand-off edge lands at index 0 of the next packet.
    repeat (3) @(negedge clk);
    base        = send_cnt_a;
    drop_before = ifa.dropped;
    send_a(8'h01);
    repeat (21) @(negedge clk);
    ifa.in_data  = 8'hEE;
    ifa.in_valid = 1'b1;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    check("sim handoff edge", 64'(ifa.busy), 64'd1);
    wait_sends_a(base + 1, 40);
    check("sim first data", sent_data_a, 64'h0100000000000000);
    check("sim first size", 64'(sent_size_a), 64'd1);
    wait_sends_a(base + 2, 120);
    check("sim second data", sent_data_a, 64'hEE00000000000000);
    check("sim second size", 64'(sent_size_a), 64'd1);
    check("sim dropped", 64'(ifa.dropped), 64'(drop_before));
    wait_busy_a(1'b0, 60, lat);

    // Reset while the FSM sits in ACK (ready held high) with 5 bytes buffered.
    hold_len_a = 0;
    base       = send_cnt_a;
    for (int j = 0; j < 8; j++) send_a(8'h21 + 8'(j));
    wait_sends_a(base + 1, 40);
    for (int j = 0; j < 5; j++) send_a(8'h31 + 8'(j));
    check("rst busy before", 64'(ifa.busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst tx_send", 64'(ifa.tx_send), 64'd0);
    check("rst tx_data", ifa.tx_data, 64'd0);
    check("rst tx_size", 64'(ifa.tx_size), 64'd0);
    check("rst busy", 64'(ifa.busy), 64'd0);
    check("rst dropped", 64'(ifa.dropped), 64'd0);
    reset      = 1'b0;
    hold_len_a = 5;
    base       = send_cnt_a;
    for (int j = 0; j < 8; j++) send_a(8'hA1 + 8'(j));
    wait_sends_a(base + 1, 40);
    check("post-rst data", sent_data_a, 64'hA1A2A3A4A5A6A7A8);
    check("post-rst size", 64'(sent_size_a), 64'd8);
    wait_busy_a(1'b0, 60, lat);
    check("post-rst busy", 64'(ifa.busy), 64'd0);

    // dut_b: TIMEOUT=0 never flushes a partial bank; drop counter saturates at 15.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("b reset dropped", 64'(ifb.dropped), 64'd0);
    send_b(8'h01);
    send_b(8'h02);
    repeat (60) @(negedge clk);
    check("b no flush busy", 64'(ifb.busy), 64'd0);
    check("b no flush size", 64'(ifb.tx_size), 64'd0);
    for (int j = 3; j <= 41; j++) begin
      send_b(8'(j));
      if (j == 30) check("b dropped 14", 64'(ifb.dropped), 64'd14);
      if (j == 31) check("b dropped 15", 64'(ifb.dropped), 64'd15);
    end
    check("b dropped saturated", 64'(ifb.dropped), 64'd15);
    check("b busy stalled", 64'(ifb.busy), 64'd1);
    check("b held data", ifb.tx_data, 64'h0102030405060708);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
